// File: rtl/sum_collector.sv
// Collects GROUP non-zero 5-bit samples into sum/max/count; result valid 1 cycle after the closing accept or flush.
// Holds the result until out_ready; in_ready drops for the whole hold, so upstream stalls rather than losing samples.
module sum_collector #(
  parameter int GROUP = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [4:0] in_data,
  output logic       in_ready,
  input  logic       flush,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_sum,
  output logic [4:0] out_max,
  output logic [3:0] out_cnt,
  output logic [7:0] skip_cnt
);

  localparam logic [3:0] GROUP_C = 4'(GROUP);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t     state_q;
  logic [7:0] acc_q, acc_d;
  logic [4:0] max_q, max_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] skip_q;
  logic       out_valid_q;
  logic [7:0] out_sum_q;
  logic [4:0] out_max_q;
  logic [3:0] out_cnt_q;
  logic       nz_acc;
  logic       zero_acc;
  logic       emit;

  // Only meaningful in ACCUM, where in_ready is high and any valid sample is accepted.
  always_comb begin
    nz_acc   = in_valid && (in_data != 5'd0);
    zero_acc = in_valid && (in_data == 5'd0);
    acc_d    = acc_q + (nz_acc ? {3'b000, in_data} : 8'd0);
    max_d    = (nz_acc && (in_data > max_q)) ? in_data : max_q;
    cnt_d    = cnt_q + {3'b000, nz_acc};
    emit     = (nz_acc && (cnt_d == GROUP_C)) || (flush && (cnt_d != 4'd0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= 8'd0;
      max_q       <= 5'd0;
      cnt_q       <= 4'd0;
      skip_q      <= 8'd0;
      out_valid_q <= 1'b0;
      out_sum_q   <= 8'd0;
      out_max_q   <= 5'd0;
      out_cnt_q   <= 4'd0;
    end else begin
      case (state_q)
        ACCUM: begin
          acc_q <= acc_d;
          max_q <= max_d;
          cnt_q <= cnt_d;
          if (zero_acc && (skip_q != 8'hFF))
            skip_q <= skip_q + 8'd1;
          if (emit) begin
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
            out_sum_q   <= acc_d;
            out_max_q   <= max_d;
            out_cnt_q   <= cnt_d;
          end
        end
        HOLD: begin
          // flush is deliberately not captured here; the group is already closed.
          if (out_ready) begin
            state_q     <= ACCUM;
            out_valid_q <= 1'b0;
            out_sum_q   <= 8'd0;
            out_max_q   <= 5'd0;
            out_cnt_q   <= 4'd0;
            acc_q       <= 8'd0;
            max_q       <= 5'd0;
            cnt_q       <= 4'd0;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_max   = out_max_q;
  assign out_cnt   = out_cnt_q;
  assign skip_cnt  = skip_q;

endmodule
